// File: rtl/alu_sequencer.sv
// Purpose: host-facing sequencer that drives an 8-bit combinational ALU and keeps a 4x8 register file.
// Latency: ALU op writes back SETTLE_CYCLES edges after accept; LOADI/READ complete in 1 cycle.
// Backpressure: instr_ready is high only in IDLE; it drops for the whole ALU settle window.
module alu_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_cin,
    output logic [3:0]  alu_s,
    input  logic [7:0]  alu_d,
    input  logic        alu_z,
    input  logic        alu_cout,
    output logic [7:0]  rd_data,
    output logic        op_done,
    output logic        flag_c,
    output logic        flag_z
);

    // Out-of-range settle values are clamped to the 1..15 window the counter supports.
    localparam int unsigned SETTLE_CLAMPED =
        (SETTLE_CYCLES < 1) ? 1 : ((SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CLAMPED);

    localparam logic [1:0] KIND_ALU   = 2'b00;
    localparam logic [1:0] KIND_LOADI = 2'b01;
    localparam logic [1:0] KIND_READ  = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [1:0]  r_dst;
    logic [7:0]  r_rf [4];
    logic        r_instr_ready;
    logic [7:0]  r_alu_a;
    logic [7:0]  r_alu_b;
    logic        r_alu_cin;
    logic [3:0]  r_alu_s;
    logic [7:0]  r_rd_data;
    logic        r_op_done;
    logic        r_flag_c;
    logic        r_flag_z;

    // Instruction field decode; fields overlap between kinds and are picked by w_kind.
    logic [1:0]  w_kind;
    logic [3:0]  w_sel;
    logic [1:0]  w_dst;
    logic [1:0]  w_src_a;
    logic [1:0]  w_src_b;
    logic        w_cin;
    logic        w_unused_bits;

    assign w_kind        = instr[15:14];
    assign w_sel         = instr[13:10];
    assign w_dst         = instr[9:8];
    assign w_src_a       = instr[7:6];
    assign w_src_b       = instr[5:4];
    assign w_cin         = instr[3] ? r_flag_c : instr[2];
    assign w_unused_bits = ^instr[1:0];

    assign instr_ready = r_instr_ready;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_cin     = r_alu_cin;
    assign alu_s       = r_alu_s;
    assign rd_data     = r_rd_data;
    assign op_done     = r_op_done;
    assign flag_c      = r_flag_c;
    assign flag_z      = r_flag_z;

    // Sequencer FSM: accepts instructions in IDLE, holds ALU inputs through DRIVE, then writes back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'd0;
            r_dst         <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_rf[i] <= 8'h00;
            end
            r_instr_ready <= 1'b1;
            r_alu_a       <= 8'h00;
            r_alu_b       <= 8'h00;
            r_alu_cin     <= 1'b0;
            r_alu_s       <= 4'h0;
            r_rd_data     <= 8'h00;
            r_op_done     <= 1'b0;
            r_flag_c      <= 1'b0;
            r_flag_z      <= 1'b0;
        end else begin
            r_op_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        case (w_kind)
                            KIND_ALU: begin
                                // Operands are latched now, so dst may alias a source safely.
                                r_alu_a       <= r_rf[w_src_a];
                                r_alu_b       <= r_rf[w_src_b];
                                r_alu_s       <= w_sel;
                                r_alu_cin     <= w_cin;
                                r_dst         <= w_dst;
                                r_cnt         <= SETTLE_INIT;
                                r_state       <= ST_DRIVE;
                                r_instr_ready <= 1'b0;
                            end
                            KIND_LOADI: begin
                                r_rf[w_dst] <= instr[7:0];
                                r_op_done   <= 1'b1;
                            end
                            KIND_READ: begin
                                r_rd_data <= r_rf[w_src_a];
                                r_op_done <= 1'b1;
                            end
                            default: begin
                                // NOP: consumed with no side effects.
                            end
                        endcase
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == 4'd1) begin
                        r_rf[r_dst]   <= alu_d;
                        r_op_done     <= 1'b1;
                        r_state       <= ST_IDLE;
                        r_instr_ready <= 1'b1;
                        // Only the arithmetic group owns the flags.
                        if (r_alu_s[3:2] == 2'b00) begin
                            r_flag_c <= alu_cout;
                            r_flag_z <= alu_z;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_instr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a behavioural ALU attached to its ALU port.
module tb_alu_sequencer;

    localparam int S = 3;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cin;
    logic [3:0]  alu_s;
    logic [7:0]  alu_d;
    logic        alu_z;
    logic        alu_cout;
    logic [7:0]  rd_data;
    logic        op_done;
    logic        flag_c;
    logic        flag_z;

    int errors = 0;
    int checks = 0;

    // Reference architectural state.
    logic [7:0] m_rf [4];
    logic       m_c;
    logic       m_z;
    logic [7:0] m_rd;

    alu_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_s(alu_s),
        .alu_d(alu_d), .alu_z(alu_z), .alu_cout(alu_cout),
        .rd_data(rd_data), .op_done(op_done), .flag_c(flag_c), .flag_z(flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {cout, z, d}. S=0001 is a forced corner (D=0, Z=1, Cout=1).
    function automatic logic [9:0] alu_f(input logic [3:0] s, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
        logic [8:0] sum;
        sum = 9'd0;
        casez (s)
            4'b0000: sum = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            4'b0001: return {1'b1, 1'b1, 8'h00};
            4'b0010: sum = {1'b0, a} + {1'b0, ~b} + {8'd0, cin};
            4'b0011: sum = {1'b0, a} + {8'd0, cin};
            4'b0100: sum = {1'b0, a & b};
            4'b0101: sum = {1'b0, a | b};
            4'b0110: sum = {1'b0, a ^ b};
            4'b0111: sum = {1'b0, ~a};
            4'b10??: sum = {a[7], a[6:0], 1'b0};
            default: sum = {a[0], 1'b0, a[7:1]};
        endcase
        return {sum[8], (sum[7:0] == 8'h00), sum[7:0]};
    endfunction

    assign {alu_cout, alu_z, alu_d} = alu_f(alu_s, alu_a, alu_b, alu_cin);

    function automatic logic [15:0] mk_alu(input logic [3:0] s, input logic [1:0] dst,
                                           input logic [1:0] sa, input logic [1:0] sb,
                                           input logic csel, input logic cimm);
        return {2'b00, s, dst, sa, sb, csel, cimm, 2'b00};
    endfunction

    function automatic logic [15:0] mk_loadi(input logic [1:0] dst, input logic [7:0] imm);
        return {2'b01, 4'h0, dst, imm};
    endfunction

    function automatic logic [15:0] mk_read(input logic [1:0] src);
        return {2'b10, 6'd0, src, 6'd0};
    endfunction

    localparam logic [15:0] NOP = 16'hC000;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_c  = 1'b0;
        m_z  = 1'b0;
        m_rd = 8'h00;
    endtask

    // Architectural effect of one instruction; also returns the ALU inputs it should present.
    task automatic model_exec(input logic [15:0] w, output logic [7:0] ea,
                              output logic [7:0] eb, output logic ec);
        logic [9:0] r;
        ea = 8'h00; eb = 8'h00; ec = 1'b0;
        case (w[15:14])
            2'b00: begin
                ea = m_rf[w[7:6]];
                eb = m_rf[w[5:4]];
                ec = w[3] ? m_c : w[2];
                r  = alu_f(w[13:10], ea, eb, ec);
                m_rf[w[9:8]] = r[7:0];
                if (w[13:12] == 2'b00) begin
                    m_c = r[9];
                    m_z = r[8];
                end
            end
            2'b01: m_rf[w[9:8]] = w[7:0];
            2'b10: m_rd = m_rf[w[7:6]];
            default: ;
        endcase
    endtask

    // Presents one instruction when the DUT is ready; returns at the negedge after acceptance.
    task automatic issue(input logic [15:0] w, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        @(negedge clk);
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) return;
        instr_valid = 1'b1;
        instr       = w;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        ok          = 1'b1;
    endtask

    // Waits (bounded) for op_done; reports cycles waited, cycles ready was low, ALU input stability.
    task automatic wait_done(output int cyc, output int low, output bit stable);
        logic [20:0] snap;
        snap   = {alu_a, alu_b, alu_s, alu_cin};
        cyc    = 0;
        low    = 0;
        stable = 1'b1;
        while (!op_done && cyc < 50) begin
            if (!instr_ready) low++;
            if ({alu_a, alu_b, alu_s, alu_cin} !== snap) stable = 1'b0;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 16'h0000;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({alu_a, alu_b, alu_cin, alu_s, rd_data, op_done, flag_c, flag_z} !== 31'd0)
            begin errors++; $display("FAIL reset_outputs got=%h want=0",
                {alu_a, alu_b, alu_cin, alu_s, rd_data, op_done, flag_c, flag_z}); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", instr_ready); end
    endtask

    task automatic test_loadi_read();
        bit ok;
        logic [7:0] ea, eb;
        logic ec;
        issue(mk_loadi(2'd0, 8'h81), ok);
        model_exec(mk_loadi(2'd0, 8'h81), ea, eb, ec);
        checks++;
        if (!ok || op_done !== 1'b1) begin errors++; $display("FAIL loadi_done ok=%0d got=%b want=1", ok, op_done); end
        issue(mk_read(2'd0), ok);
        model_exec(mk_read(2'd0), ea, eb, ec);
        checks++;
        if (!ok || op_done !== 1'b1 || rd_data !== m_rd)
            begin errors++; $display("FAIL read_r0 done=%b got=%h want=%h", op_done, rd_data, m_rd); end
        @(negedge clk);
        checks++;
        if (op_done !== 1'b0) begin errors++; $display("FAIL done_single_pulse got=%b want=0", op_done); end
        checks++;
        if ({flag_c, flag_z} !== 2'b00) begin errors++; $display("FAIL flags_after_load got=%b want=00", {flag_c, flag_z}); end
    endtask

    task automatic test_shift();
        bit ok, stable;
        int cyc, low;
        logic [7:0] ea, eb;
        logic ec;
        logic [15:0] w;
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? mk_alu(4'b1000, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0)
                         : mk_alu(4'b1100, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0);
            issue(w, ok);
            model_exec(w, ea, eb, ec);
            checks++;
            if (!ok || alu_s !== w[13:10] || alu_a !== ea)
                begin errors++; $display("FAIL shift%0d_inputs s=%b a=%h want s=%b a=%h", k, alu_s, alu_a, w[13:10], ea); end
            wait_done(cyc, low, stable);
            checks++;
            if (cyc !== S || low !== S || !stable)
                begin errors++; $display("FAIL shift%0d_timing cyc=%0d low=%0d stable=%0d want %0d/%0d/1", k, cyc, low, stable, S, S); end
            issue(mk_read(w[9:8]), ok);
            model_exec(mk_read(w[9:8]), ea, eb, ec);
            checks++;
            if (!ok || rd_data !== m_rd)
                begin errors++; $display("FAIL shift%0d_result got=%h want=%h", k, rd_data, m_rd); end
            checks++;
            if ({flag_c, flag_z} !== {m_c, m_z})
                begin errors++; $display("FAIL shift%0d_flags got=%b want=%b", k, {flag_c, flag_z}, {m_c, m_z}); end
        end
    endtask

    task automatic test_flags();
        bit ok, stable;
        int cyc, low;
        logic [7:0] ea, eb;
        logic ec;
        logic [15:0] w;
        w = mk_alu(4'b0001, 2'd3, 2'd0, 2'd1, 1'b0, 1'b0);
        issue(w, ok);
        model_exec(w, ea, eb, ec);
        wait_done(cyc, low, stable);
        checks++;
        if (!ok || cyc !== S || {flag_c, flag_z} !== 2'b11)
            begin errors++; $display("FAIL forced_flags cyc=%0d got=%b want=11", cyc, {flag_c, flag_z}); end
        issue(mk_read(2'd3), ok);
        model_exec(mk_read(2'd3), ea, eb, ec);
        checks++;
        if (!ok || rd_data !== 8'h00) begin errors++; $display("FAIL forced_r3 got=%h want=00", rd_data); end
        w = mk_alu(4'b0000, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0);
        issue(w, ok);
        model_exec(w, ea, eb, ec);
        checks++;
        if (!ok || alu_cin !== 1'b1) begin errors++; $display("FAIL cin_from_flag got=%b want=1", alu_cin); end
        wait_done(cyc, low, stable);
        checks++;
        if ({flag_c, flag_z} !== {m_c, m_z})
            begin errors++; $display("FAIL add_flags got=%b want=%b", {flag_c, flag_z}, {m_c, m_z}); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int seen;
        logic [7:0] ea, eb;
        logic ec;
        issue(mk_loadi(2'd1, 8'h5A), ok);
        model_exec(mk_loadi(2'd1, 8'h5A), ea, eb, ec);
        issue(mk_alu(4'b0000, 2'd1, 2'd1, 2'd1, 1'b0, 1'b0), ok);
        checks++;
        if (!ok || instr_ready !== 1'b0) begin errors++; $display("FAIL mid_in_drive ready=%b want=0", instr_ready); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_cin, alu_s, rd_data, op_done, flag_c, flag_z} !== 31'd0)
            begin errors++; $display("FAIL mid_reset_outputs got=%h want=0",
                {alu_a, alu_b, alu_cin, alu_s, rd_data, op_done, flag_c, flag_z}); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < S + 2; i++) begin
            if (op_done) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0 || instr_ready !== 1'b1)
            begin errors++; $display("FAIL mid_no_done done_seen=%0d ready=%b want 0/1", seen, instr_ready); end
        issue(mk_read(2'd1), ok);
        model_exec(mk_read(2'd1), ea, eb, ec);
        checks++;
        if (!ok || rd_data !== m_rd) begin errors++; $display("FAIL mid_r1_cleared got=%h want=%h", rd_data, m_rd); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] st [5];
        bit exp_done [$];
        bit chk_rd [$];
        logic [7:0] exp_rd [$];
        bit obs_done [$];
        logic [7:0] obs_rd [$];
        logic [7:0] ea, eb;
        logic ec;
        logic rdy;
        int idx, guard;
        st[0] = mk_loadi(2'd2, 8'(8'h30 + $urandom_range(0, 15)));
        st[1] = NOP;
        st[2] = mk_read(2'd2);
        st[3] = mk_alu(4'b0011, 2'd0, 2'd2, 2'd1, 1'b0, 1'b1);
        st[4] = mk_read(2'd0);
        for (int i = 0; i < 5; i++) begin
            model_exec(st[i], ea, eb, ec);
            case (st[i][15:14])
                2'b00: begin
                    for (int j = 0; j < S; j++) begin
                        exp_done.push_back(1'b0); chk_rd.push_back(1'b0); exp_rd.push_back(8'h00);
                    end
                    exp_done.push_back(1'b1); chk_rd.push_back(1'b0); exp_rd.push_back(8'h00);
                end
                2'b11: begin exp_done.push_back(1'b0); chk_rd.push_back(1'b0); exp_rd.push_back(8'h00); end
                2'b10: begin exp_done.push_back(1'b1); chk_rd.push_back(1'b1); exp_rd.push_back(m_rd); end
                default: begin exp_done.push_back(1'b1); chk_rd.push_back(1'b0); exp_rd.push_back(8'h00); end
            endcase
        end
        @(negedge clk);
        idx = 0;
        guard = 0;
        instr_valid = 1'b1;
        instr = st[0];
        while (obs_done.size() < exp_done.size() && guard < 200) begin
            rdy = instr_ready;
            @(posedge clk);
            if (rdy && instr_valid) idx++;
            @(negedge clk);
            if (idx > 0) begin
                obs_done.push_back(op_done);
                obs_rd.push_back(rd_data);
            end
            if (idx < 5) instr = st[idx];
            else instr_valid = 1'b0;
            guard++;
        end
        instr_valid = 1'b0;
        checks++;
        if (obs_done.size() != exp_done.size())
            begin errors++; $display("FAIL stream_length got=%0d want=%0d", obs_done.size(), exp_done.size()); end
        for (int i = 0; i < exp_done.size() && i < obs_done.size(); i++) begin
            checks++;
            if (obs_done[i] !== exp_done[i])
                begin errors++; $display("FAIL stream_done[%0d] got=%b want=%b", i, obs_done[i], exp_done[i]); end
            if (chk_rd[i]) begin
                checks++;
                if (obs_rd[i] !== exp_rd[i])
                    begin errors++; $display("FAIL stream_rd[%0d] got=%h want=%h", i, obs_rd[i], exp_rd[i]); end
            end
        end
    endtask

    task automatic test_random();
        bit ok, stable;
        int cyc, low;
        logic [7:0] ea, eb;
        logic ec;
        logic [15:0] w;
        for (int it = 0; it < 60; it++) begin
            w = 16'($urandom);
            issue(w, ok);
            model_exec(w, ea, eb, ec);
            checks++;
            if (!ok) begin errors++; $display("FAIL rnd%0d_accept timeout", it); end
            case (w[15:14])
                2'b00: begin
                    checks++;
                    if ({alu_a, alu_b, alu_s, alu_cin, op_done} !== {ea, eb, w[13:10], ec, 1'b0})
                        begin errors++; $display("FAIL rnd%0d_alu_in got=%h %h %b %b want=%h %h %b %b", it,
                            alu_a, alu_b, alu_s, alu_cin, ea, eb, w[13:10], ec); end
                    wait_done(cyc, low, stable);
                    checks++;
                    if (cyc !== S) begin errors++; $display("FAIL rnd%0d_latency got=%0d want=%0d", it, cyc, S); end
                end
                2'b10: begin
                    checks++;
                    if (op_done !== 1'b1 || rd_data !== m_rd)
                        begin errors++; $display("FAIL rnd%0d_read done=%b got=%h want=%h", it, op_done, rd_data, m_rd); end
                end
                2'b01: begin
                    checks++;
                    if (op_done !== 1'b1) begin errors++; $display("FAIL rnd%0d_loadi_done got=%b want=1", it, op_done); end
                end
                default: begin
                    checks++;
                    if (op_done !== 1'b0 || instr_ready !== 1'b1)
                        begin errors++; $display("FAIL rnd%0d_nop done=%b ready=%b want 0/1", it, op_done, instr_ready); end
                end
            endcase
            checks++;
            if ({flag_c, flag_z} !== {m_c, m_z})
                begin errors++; $display("FAIL rnd%0d_flags got=%b want=%b", it, {flag_c, flag_z}, {m_c, m_z}); end
        end
        for (int r = 0; r < 4; r++) begin
            issue(mk_read(2'(r)), ok);
            model_exec(mk_read(2'(r)), ea, eb, ec);
            checks++;
            if (!ok || rd_data !== m_rd)
                begin errors++; $display("FAIL final_r%0d got=%h want=%h", r, rd_data, m_rd); end
        end
    endtask

    initial begin
        test_reset();
        test_loadi_read();
        test_shift();
        test_flags();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
